// File: rtl/svnet_ram_arbiter_pkg.sv
// Shared types and helpers for the svnet RAM arbiter: the read-tag pipeline entry
// and the round-robin pointer increment.
package svnet_ram_arbiter_pkg;

  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned ID_W_MAX   = 8;

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } rd_tag_t;

  function automatic rd_tag_t make_tag(input logic valid, input logic [ID_W_MAX-1:0] id);
    rd_tag_t tag;
    tag.valid = valid;
    tag.id    = id;
    return tag;
  endfunction

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/svnet_ram.sv
// Simple dual-port RAM: write visible to reads one cycle later, read data two cycles
// after the read address is presented.
module svnet_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_stage_q;
  logic [WIDTH-1:0] rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rd_stage_q <= mem_q[raddr_i];
    end
    rdata_q <= rd_stage_q;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/svnet_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, and moves
// the pointer past the winner when advancing is enabled.
module svnet_rr_arbiter
  import svnet_ram_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTERS = 4,
  localparam int unsigned IW        = $clog2(REQUESTERS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [REQUESTERS-1:0] req_i,
  input  logic                  adv_en_i,
  output logic [REQUESTERS-1:0] gnt_c_o,
  output logic [IW-1:0]         idx_c_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      cand = IW'((32'(ptr_q) + k) % REQUESTERS);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        gnt_c_o[cand] = 1'b1;
        idx_c_o       = cand;
      end
    end
    ptr_d = ptr_q;
    if (adv_en_i && found) begin
      ptr_d = IW'(next_idx(32'(idx_c_o), REQUESTERS));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/svnet_ram_arbiter.sv
// Shares one svnet_ram between several clients with independent round-robin write and
// read arbiters; returning read data is steered back to the client that issued it.
module svnet_ram_arbiter
  import svnet_ram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned REQUESTERS = 4,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned IW        = $clog2(REQUESTERS)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [REQUESTERS-1:0]            wr_req_i,
  input  logic [REQUESTERS-1:0][AW-1:0]    wr_addr_i,
  input  logic [REQUESTERS-1:0][WIDTH-1:0] wr_data_i,
  output logic [REQUESTERS-1:0]            wr_gnt_o,
  input  logic [REQUESTERS-1:0]            rd_req_i,
  input  logic [REQUESTERS-1:0][AW-1:0]    rd_addr_i,
  output logic [REQUESTERS-1:0]            rd_gnt_o,
  output logic [REQUESTERS-1:0]            rd_data_valid_o,
  output logic [WIDTH-1:0]                 rd_data_o
);

  logic [REQUESTERS-1:0] wr_cand;
  logic [REQUESTERS-1:0] rd_cand;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [AW-1:0]         wr_addr_c;
  logic [WIDTH-1:0]      wr_data_c;
  logic [AW-1:0]         rd_addr_c;
  logic                  wr_en_c;
  logic                  rd_en_c;
  logic                  collide_c;

  rd_tag_t [RD_LATENCY-1:0] tag_q;

  svnet_rr_arbiter #(.REQUESTERS(REQUESTERS)) u_wr_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (wr_req_i),
    .adv_en_i(1'b1),
    .gnt_c_o (wr_cand),
    .idx_c_o (wr_idx)
  );

  // A read colliding with the same-cycle write waits; its pointer must not move.
  svnet_rr_arbiter #(.REQUESTERS(REQUESTERS)) u_rd_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (rd_req_i),
    .adv_en_i(!collide_c),
    .gnt_c_o (rd_cand),
    .idx_c_o (rd_idx)
  );

  always_comb begin
    wr_addr_c = wr_addr_i[wr_idx];
    wr_data_c = wr_data_i[wr_idx];
    rd_addr_c = rd_addr_i[rd_idx];
    wr_en_c   = rst_n_i && (|wr_cand);
    collide_c = wr_en_c && (|rd_cand) && (rd_addr_c == wr_addr_c);
    rd_en_c   = rst_n_i && (|rd_cand) && !collide_c;
    wr_gnt_o  = wr_en_c ? wr_cand : '0;
    rd_gnt_o  = rd_en_c ? rd_cand : '0;
  end

  svnet_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk_i  (clk_i),
    .we_i   (wr_en_c),
    .waddr_i(wr_addr_c),
    .wdata_i(wr_data_c),
    .re_i   (rd_en_c),
    .raddr_i(rd_addr_c),
    .rdata_o(rd_data_o)
  );

  // Requester-ID shadow of the RAM read pipeline.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= make_tag(rd_en_c, ID_W_MAX'(rd_idx));
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    rd_data_valid_o = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      rd_data_valid_o[i] = rst_n_i && tag_q[RD_LATENCY-1].valid &&
                           (tag_q[RD_LATENCY-1].id == ID_W_MAX'(i));
    end
  end

  a_wr_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(wr_gnt_o));
  a_rd_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(rd_gnt_o));
  a_rd_dv_onehot:  assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(rd_data_valid_o));
  a_wr_addr_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                    wr_en_c |-> (32'(wr_addr_c) < DEPTH));
  a_rd_addr_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                    rd_en_c |-> (32'(rd_addr_c) < DEPTH));

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_stable
    a_wr_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (wr_req_i[g] && !wr_gnt_o[g]) |=>
        (!wr_req_i[g] || ($stable(wr_addr_i[g]) && $stable(wr_data_i[g]))));
    a_rd_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (rd_req_i[g] && !rd_gnt_o[g]) |=> (!rd_req_i[g] || $stable(rd_addr_i[g])));
  end

endmodule

// File: tb/tb_svnet_ram_arbiter.sv
// Directed self-checking bench for svnet_ram_arbiter.
module tb_svnet_ram_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned REQ   = 4;
  localparam int unsigned AW    = 8;

  logic                      clk_i = 1'b0;
  logic                      rst_n_i;
  logic [REQ-1:0]            wr_req;
  logic [REQ-1:0][AW-1:0]    wr_addr;
  logic [REQ-1:0][WIDTH-1:0] wr_data;
  logic [REQ-1:0]            wr_gnt;
  logic [REQ-1:0]            rd_req;
  logic [REQ-1:0][AW-1:0]    rd_addr;
  logic [REQ-1:0]            rd_gnt;
  logic [REQ-1:0]            rd_dv;
  logic [WIDTH-1:0]          rd_data;

  logic [WIDTH-1:0] exp_mem [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  svnet_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REQUESTERS(REQ)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .wr_req_i       (wr_req),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .wr_gnt_o       (wr_gnt),
    .rd_req_i       (rd_req),
    .rd_addr_i      (rd_addr),
    .rd_gnt_o       (rd_gnt),
    .rd_data_valid_o(rd_dv),
    .rd_data_o      (rd_data)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    wr_req = '1;
    rd_req = '1;
    settle();
    n_checks++;
    if (wr_gnt !== 4'b0000) $display("FAIL reset_wr_gnt: got %b expected 0000", wr_gnt);
    else n_pass++;
    n_checks++;
    if (rd_gnt !== 4'b0000) $display("FAIL reset_rd_gnt: got %b expected 0000", rd_gnt);
    else n_pass++;
    n_checks++;
    if (rd_dv !== 4'b0000) $display("FAIL reset_rd_dv: got %b expected 0000", rd_dv);
    else n_pass++;
    wr_req = '0;
    rd_req = '0;
    step();
    rst_n_i = 1'b1;
    settle();
    n_checks++;
    if ({wr_gnt, rd_gnt, rd_dv} !== 12'h000)
      $display("FAIL idle_no_gnt: got %b expected all zero", {wr_gnt, rd_gnt, rd_dv});
    else n_pass++;
    step();
  endtask

  task automatic test_preload();
    for (int k = 0; k < 8; k++) begin
      wr_req     = 4'b0001;
      wr_addr[0] = AW'(k);
      wr_data[0] = (k == 4) ? 8'h3C : WIDTH'(8'h10 + k);
      exp_mem[k] = wr_data[0];
      settle();
      n_checks++;
      if (wr_gnt !== 4'b0001) $display("FAIL preload_wr_gnt[%0d]: got %b expected 0001", k, wr_gnt);
      else n_pass++;
      step();
    end
    wr_req = '0;
    step();
  endtask

  task automatic test_single_reads();
    logic [REQ-1:0] exp_v;
    for (int c = 0; c < REQ; c++) rd_addr[c] = AW'(c);
    for (int n = 0; n < 6; n++) begin
      rd_req = (n < 4) ? (REQ'(1) << n) : '0;
      settle();
      if (n < 4) begin
        n_checks++;
        if (rd_gnt !== (REQ'(1) << n))
          $display("FAIL single_rd_gnt[%0d]: got %b expected %b", n, rd_gnt, REQ'(1) << n);
        else n_pass++;
      end
      exp_v = (n >= 2) ? (REQ'(1) << (n - 2)) : '0;
      n_checks++;
      if (rd_dv !== exp_v) $display("FAIL single_rd_dv[%0d]: got %b expected %b", n, rd_dv, exp_v);
      else n_pass++;
      if (n >= 2) begin
        n_checks++;
        if (rd_data !== exp_mem[n-2])
          $display("FAIL single_rd_data[%0d]: got %h expected %h", n, rd_data, exp_mem[n-2]);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_rr_sweep();
    logic [REQ-1:0] exp_v;
    for (int n = 0; n < 10; n++) begin
      rd_req = (n < 8) ? 4'b1111 : 4'b0000;
      settle();
      if (n < 8) begin
        n_checks++;
        if (rd_gnt !== (REQ'(1) << (n % 4)))
          $display("FAIL sweep_rd_gnt[%0d]: got %b expected %b", n, rd_gnt, REQ'(1) << (n % 4));
        else n_pass++;
      end
      exp_v = (n >= 2) ? (REQ'(1) << ((n - 2) % 4)) : '0;
      n_checks++;
      if (rd_dv !== exp_v) $display("FAIL sweep_rd_dv[%0d]: got %b expected %b", n, rd_dv, exp_v);
      else n_pass++;
      if (n >= 2) begin
        n_checks++;
        if (rd_data !== exp_mem[(n-2)%4])
          $display("FAIL sweep_rd_data[%0d]: got %h expected %h", n, rd_data, exp_mem[(n-2)%4]);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_collision();
    wr_req = 4'b0010; wr_addr[1] = 8'd10; wr_data[1] = 8'hA5;
    rd_req = 4'b0100; rd_addr[2] = 8'd10;
    exp_mem[10] = 8'hA5;
    settle();
    n_checks++;
    if (wr_gnt !== 4'b0010) $display("FAIL coll_wr_gnt: got %b expected 0010", wr_gnt);
    else n_pass++;
    n_checks++;
    if (rd_gnt !== 4'b0000) $display("FAIL coll_rd_stall: got %b expected 0000", rd_gnt);
    else n_pass++;
    step();
    wr_req = '0;
    settle();
    n_checks++;
    if (rd_gnt !== 4'b0100) $display("FAIL coll_rd_retry: got %b expected 0100", rd_gnt);
    else n_pass++;
    step();
    rd_req = '0;
    settle();
    n_checks++;
    if (rd_dv !== 4'b0000) $display("FAIL coll_rd_dv_early: got %b expected 0000", rd_dv);
    else n_pass++;
    step();
    settle();
    n_checks++;
    if (rd_dv !== 4'b0100) $display("FAIL coll_rd_dv: got %b expected 0100", rd_dv);
    else n_pass++;
    n_checks++;
    if (rd_data !== 8'hA5) $display("FAIL coll_rd_data: got %h expected a5", rd_data);
    else n_pass++;
    step();
  endtask

  task automatic test_diff_addr();
    wr_req = 4'b0001; wr_addr[0] = 8'd3; wr_data[0] = 8'h77;
    rd_req = 4'b1000; rd_addr[3] = 8'd4;
    exp_mem[3] = 8'h77;
    settle();
    n_checks++;
    if ({wr_gnt, rd_gnt} !== 8'b0001_1000)
      $display("FAIL diff_gnts: got %b expected 00011000", {wr_gnt, rd_gnt});
    else n_pass++;
    step();
    wr_req = '0; rd_req = '0;
    step();
    settle();
    n_checks++;
    if (rd_dv !== 4'b1000) $display("FAIL diff_rd_dv: got %b expected 1000", rd_dv);
    else n_pass++;
    n_checks++;
    if (rd_data !== 8'h3C) $display("FAIL diff_rd_data: got %h expected 3c", rd_data);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    rd_req = 4'b0010; rd_addr[1] = 8'd5;
    wr_req = 4'b0100; wr_addr[2] = 8'd20; wr_data[2] = 8'h55;
    exp_mem[20] = 8'h55;
    settle();
    n_checks++;
    if ({wr_gnt, rd_gnt} !== 8'b0100_0010)
      $display("FAIL rstmid_pre_gnts: got %b expected 01000010", {wr_gnt, rd_gnt});
    else n_pass++;
    step();
    rd_req = '0; wr_req = '0;
    rst_n_i = 1'b0;
    settle();
    n_checks++;
    if (rd_dv !== 4'b0000) $display("FAIL rstmid_dv_in_reset: got %b expected 0000", rd_dv);
    else n_pass++;
    step();
    rst_n_i = 1'b1;
    rd_req = 4'b1010; rd_addr[1] = 8'd6; rd_addr[3] = 8'd7;
    wr_req = 4'b1010; wr_addr[1] = 8'd30; wr_addr[3] = 8'd31;
    wr_data[1] = 8'hE1; wr_data[3] = 8'hE3;
    exp_mem[30] = 8'hE1;
    settle();
    n_checks++;
    if (rd_dv !== 4'b0000) $display("FAIL rstmid_dropped_read: got %b expected 0000", rd_dv);
    else n_pass++;
    n_checks++;
    if (rd_gnt !== 4'b0010) $display("FAIL rstmid_rd_ptr0: got %b expected 0010", rd_gnt);
    else n_pass++;
    n_checks++;
    if (wr_gnt !== 4'b0010) $display("FAIL rstmid_wr_ptr0: got %b expected 0010", wr_gnt);
    else n_pass++;
    step();
    rd_req = '0; wr_req = '0;
    settle();
    n_checks++;
    if (rd_dv !== 4'b0000) $display("FAIL rstmid_dv_gap: got %b expected 0000", rd_dv);
    else n_pass++;
    step();
    settle();
    n_checks++;
    if (rd_dv !== 4'b0010 || rd_data !== exp_mem[6])
      $display("FAIL rstmid_post_read: got %b/%h expected 0010/%h", rd_dv, rd_data, exp_mem[6]);
    else n_pass++;
    step();
  endtask

  task automatic test_wr_fairness();
    int c0_grants;
    logic [REQ-1:0] exp_g;
    c0_grants = 0;
    for (int c = 0; c < REQ; c++) begin
      wr_addr[c] = AW'(40 + c);
      wr_data[c] = WIDTH'(8'hB0 + c);
    end
    for (int n = 0; n < 8; n++) begin
      wr_req = 4'b1111;
      settle();
      exp_g = REQ'(1) << ((2 + n) % 4);
      n_checks++;
      if (wr_gnt !== exp_g) $display("FAIL fair_wr_gnt[%0d]: got %b expected %b", n, wr_gnt, exp_g);
      else n_pass++;
      if (wr_gnt[0] === 1'b1) c0_grants++;
      step();
    end
    wr_req = '0;
    n_checks++;
    if (c0_grants != 2) $display("FAIL fair_c0_count: got %0d expected 2", c0_grants);
    else n_pass++;
    step();
  endtask

  task automatic test_readback();
    rd_req = 4'b0001; rd_addr[0] = 8'd40;
    settle();
    n_checks++;
    if (rd_gnt !== 4'b0001) $display("FAIL rb_rd_gnt: got %b expected 0001", rd_gnt);
    else n_pass++;
    step();
    rd_req = '0;
    step();
    settle();
    n_checks++;
    if (rd_dv !== 4'b0001 || rd_data !== 8'hB0)
      $display("FAIL rb_rd_data: got %b/%h expected 0001/b0", rd_dv, rd_data);
    else n_pass++;
    step();
  endtask

  initial begin
    rst_n_i = 1'b0;
    wr_req  = '0;
    rd_req  = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    step();
    step();
    test_reset();
    test_preload();
    test_single_reads();
    test_rr_sweep();
    test_collision();
    test_diff_addr();
    test_reset_mid();
    test_wr_fairness();
    test_readback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
